// File: rtl/dds_pinc_scheduler.sv
// Time-multiplexed DDS phase-increment scheduler: streams active[ch] per channel over AXI-Stream,
// with a shadow table copied atomically into the active table at frame boundaries, plus a stall watchdog.
module dds_pinc_scheduler #(
  parameter int N_CHAN      = 8,
  parameter int PINC_W      = 32,
  parameter int STALL_LIMIT = 1024,
  localparam int CW = $clog2(N_CHAN),
  localparam int SW = $clog2(STALL_LIMIT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_wr,
  input  logic [CW-1:0]     cfg_addr,
  input  logic [PINC_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              commit_pending,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [PINC_W-1:0] m_axis_tdata,
  output logic [CW-1:0]     m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              stall
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_ch;
  logic [PINC_W-1:0] r_shadow [N_CHAN];
  logic [PINC_W-1:0] r_active [N_CHAN];
  logic              r_pending;
  logic [SW-1:0]     r_cnt;
  logic              r_stall;

  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic              w_boundary;
  logic [SW-1:0]     w_cnt_next;

  assign w_valid    = (r_state == S_RUN);
  assign w_last     = (r_ch == CW'(N_CHAN - 1));
  assign w_hs       = w_valid & m_axis_tready;
  assign w_boundary = (r_state == S_IDLE) | (w_hs & w_last);

  assign m_axis_tvalid  = w_valid;
  assign m_axis_tdata   = r_active[r_ch];
  assign m_axis_tuser   = r_ch;
  assign m_axis_tlast   = w_last;
  assign commit_pending = r_pending;
  assign stall          = r_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CHAN; i++) r_shadow[i] <= '0;
    end else if (cfg_wr) begin
      r_shadow[cfg_addr] <= cfg_data;
    end
  end

  // The copy samples shadow before this edge's write, so a write on the swap edge waits for the next commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CHAN; i++) r_active[i] <= '0;
      r_pending <= 1'b0;
    end else if (r_pending && w_boundary) begin
      for (int i = 0; i < N_CHAN; i++) r_active[i] <= r_shadow[i];
      r_pending <= 1'b0;
    end else if (cfg_commit) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ch <= '0;
          if (enable) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_hs) begin
            r_ch <= r_ch + CW'(1);
            if (w_last && !enable) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_valid || w_hs)
      w_cnt_next = '0;
    else if (r_cnt != SW'(STALL_LIMIT))
      w_cnt_next = r_cnt + SW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_stall <= (w_cnt_next == SW'(STALL_LIMIT));
    end
  end

endmodule

// File: tb/tb_dds_pinc_scheduler.sv
// Directed bench for dds_pinc_scheduler: a vector table for the streaming/commit/backpressure frames,
// then hand-written sequences for the watchdog, enable drop and asynchronous reset.
module tb_dds_pinc_scheduler;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_commit;
  logic        commit_pending;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [2:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic        stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic        en, rdy, wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        commit;
    logic        vld;
    logic [31:0] td;
    logic [2:0]  tu;
    logic        last, pend, stl;
  } vec_t;

  vec_t vecs[$];

  dds_pinc_scheduler #(.N_CHAN(8), .PINC_W(32), .STALL_LIMIT(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] oldVal(int i);
    return 32'h1000 * (i + 1);
  endfunction

  function automatic vec_t mk(string tag, logic en, logic rdy, logic wr, logic [2:0] addr,
                              logic [31:0] data, logic commit, logic vld, logic [31:0] td,
                              logic [2:0] tu, logic last, logic pend, logic stl);
    vec_t v;
    v.tag = tag; v.en = en; v.rdy = rdy; v.wr = wr; v.addr = addr; v.data = data;
    v.commit = commit; v.vld = vld; v.td = td; v.tu = tu; v.last = last; v.pend = pend; v.stl = stl;
    return v;
  endfunction

  task automatic cmp(string tag, string field, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s.%s got=%h want=%h", tag, field, act, exp);
    end
  endtask

  // Inputs change on the falling edge so they are stable at the next rising edge.
  task automatic applyStimulus(vec_t v);
    @(negedge clock);
    enable        = v.en;
    m_axis_tready = v.rdy;
    cfg_wr        = v.wr;
    cfg_addr      = v.addr;
    cfg_data      = v.data;
    cfg_commit    = v.commit;
  endtask

  task automatic checkOutput(vec_t v);
    cmp(v.tag, "tvalid", 32'(m_axis_tvalid), 32'(v.vld));
    if (v.vld) begin
      cmp(v.tag, "tdata", m_axis_tdata, v.td);
      cmp(v.tag, "tuser", 32'(m_axis_tuser), 32'(v.tu));
      cmp(v.tag, "tlast", 32'(m_axis_tlast), 32'(v.last));
    end
    cmp(v.tag, "pending", 32'(commit_pending), 32'(v.pend));
    cmp(v.tag, "stall", 32'(stall), 32'(v.stl));
  endtask

  task automatic step(vec_t v);
    applyStimulus(v);
    #1;
    checkOutput(v);
  endtask

  task automatic checkResetOutputs(string tag);
    cmp(tag, "tvalid", 32'(m_axis_tvalid), 32'd0);
    cmp(tag, "tdata", m_axis_tdata, 32'd0);
    cmp(tag, "tuser", 32'(m_axis_tuser), 32'd0);
    cmp(tag, "tlast", 32'(m_axis_tlast), 32'd0);
    cmp(tag, "pending", 32'(commit_pending), 32'd0);
    cmp(tag, "stall", 32'(stall), 32'd0);
  endtask

  logic [31:0] newv [8];

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; m_axis_tready = 1'b0;

    // Frame contents after the mid-frame commit: ch0..3 rewritten, ch4 written on the swap edge.
    for (int i = 0; i < 8; i++) newv[i] = (i < 4) ? 32'hA000_0000 : oldVal(i);

    // Load shadow, commit in IDLE, then stream two frames without bubbles.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("t1_wr%0d", i), 0, 0, 1, 3'(i), oldVal(i), 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_commit", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t1_enable", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk($sformatf("t1_beat%0d", k), 1, 1, 0, 0, 0, 0,
                        1, oldVal(k % 8), 3'(k % 8), (k % 8) == 7, 0, 0));

    // Mid-frame commit: writes on beats 3..7 to ch0..4, commit on beat 3.
    for (int k = 0; k < 8; k++) begin
      if (k < 3)
        vecs.push_back(mk($sformatf("t2_beat%0d", k), 1, 1, 0, 0, 0, 0,
                          1, oldVal(k), 3'(k), 0, 0, 0));
      else
        vecs.push_back(mk($sformatf("t2_beat%0d", k), 1, 1, 1, 3'(k - 3), 32'hA000_0000, k == 3,
                          1, oldVal(k), 3'(k), k == 7, k != 3, 0));
    end

    // New frame with 5 cycles of backpressure on ch2.
    vecs.push_back(mk("t3_beat0", 1, 1, 0, 0, 0, 0, 1, newv[0], 3'd0, 0, 0, 0));
    vecs.push_back(mk("t3_beat1", 1, 1, 0, 0, 0, 0, 1, newv[1], 3'd1, 0, 0, 0));
    for (int c = 0; c < 5; c++)
      vecs.push_back(mk($sformatf("t3_hold%0d", c), 1, 0, 0, 0, 0, 0, 1, newv[2], 3'd2, 0, 0, 0));
    for (int k = 2; k < 8; k++)
      vecs.push_back(mk($sformatf("t3_beat%0d", k), 1, 1, 0, 0, 0, 0,
                        1, newv[k], 3'(k), k == 7, 0, 0));

    #23;
    checkResetOutputs("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Watchdog: 20 backpressured cycles on ch0, then one handshake.
    for (int c = 0; c < 20; c++)
      step(mk($sformatf("t4_bp%0d", c), 1, 0, 0, 0, 0, 0, 1, newv[0], 3'd0, 0, 0, c >= 16));
    step(mk("t4_release", 1, 1, 0, 0, 0, 0, 1, newv[0], 3'd0, 0, 0, 1));
    for (int k = 1; k < 8; k++)
      step(mk($sformatf("t4_beat%0d", k), 1, 1, 0, 0, 0, 0, 1, newv[k], 3'(k), k == 7, 0, 0));

    // Enable dropped at beat 4: frame completes, then IDLE, then restart at ch0.
    for (int k = 0; k < 8; k++)
      step(mk($sformatf("t5_beat%0d", k), k < 4, 1, 0, 0, 0, 0, 1, newv[k], 3'(k), k == 7, 0, 0));
    step(mk("t5_idle0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("t5_idle1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk("t5_reen", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step(mk($sformatf("t5_restart%0d", k), 1, 1, 0, 0, 0, 0, 1, newv[k], 3'(k), 0, 0, 0));

    // Async reset mid-frame with a commit pending.
    step(mk("t6_commit", 1, 1, 1, 3'd5, 32'hDEAD_BEEF, 1, 1, newv[3], 3'd3, 0, 0, 0));
    step(mk("t6_pending", 1, 1, 0, 0, 0, 0, 1, newv[4], 3'd4, 0, 1, 0));
    #2;
    reset = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    @(negedge clock);
    reset = 1'b0; enable = 1'b0; m_axis_tready = 1'b0;
    step(mk("t6_reen", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      step(mk($sformatf("t6_beat%0d", k), 1, 1, 0, 0, 0, 0, 1, 32'd0, 3'(k), k == 7, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_pinc_scheduler.md
Name: dds_pinc_scheduler

Overview:
- Time-multiplexed phase-increment scheduler feeding the dds_pinc datapath over AXI-Stream: one PINC word per channel, channel 0..N_CHAN-1, repeating.
- Holds a host-writable shadow table and an active table; shadow-to-active copy is atomic at frame boundaries, so the DDS never sees a half-updated frame.
- Includes a stall watchdog that flags sustained downstream backpressure, complementing the HLS deadlock monitors.

Parameters:
- N_CHAN, 8, channels per frame; power of two, >= 2
- PINC_W, 32, phase-increment width in bits
- STALL_LIMIT, 1024, consecutive backpressured cycles before stall asserts; >= 1

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = stream frames, 0 = stop after current frame
- cfg_wr  in  1  shadow table write strobe
- cfg_addr  in  log2(N_CHAN)  shadow table channel index
- cfg_data  in  PINC_W  shadow table write data
- cfg_commit  in  1  request shadow-to-active copy (pulse)
- commit_pending  out  1  commit requested, not yet applied
- m_axis_tvalid  out  1  PINC beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  PINC_W  active[ch]
- m_axis_tuser  out  log2(N_CHAN)  channel index ch
- m_axis_tlast  out  1  ch == N_CHAN-1
- stall  out  1  watchdog flag

Behaviour:
- Reset (asynchronous, active-high): both tables all zeros, ch=0, state IDLE, tvalid=0, commit_pending=0, stall=0, stall counter=0. Reset mid-frame abandons the frame; the next frame starts at ch=0.
- cfg_wr writes shadow[cfg_addr] at the clock edge, in any state. Active table is never written directly.
- cfg_commit sets commit_pending at the edge. A commit while already pending has no further effect.
- Swap: when commit_pending=1 at a boundary cycle, all active[i] <= shadow[i] and commit_pending <= 0 on that edge.
  - Boundary cycle is either (state IDLE) or (tvalid & tready & tlast).
  - A cfg_wr in the same cycle as cfg_commit is included in the copy, because the copy occurs at least one edge later.
  - A cfg_wr on the swap edge is not included; it stays in shadow for the next commit.
- FSM:
  - IDLE: tvalid=0. Go to RUN when enable=1, with ch=0.
  - RUN: tvalid=1. On a handshake, ch <= ch+1 and wraps from N_CHAN-1 to 0. If a tlast beat is accepted and enable=0, go to IDLE. If enable=0 earlier in the frame, keep streaming until tlast is accepted (no partial frames).
- AXI-Stream rules:
  - While tvalid=1 and tready=0, tdata/tuser/tlast are held stable.
  - Active table only changes on the tlast-accept edge or in IDLE, so tdata stability holds.
  - tvalid never deasserts without a handshake.
  - Back-to-back beats at 1/clock when tready=1.
  - Outputs are combinational from registered ch/state/active; no extra latency. First beat appears the cycle after enable is sampled high in IDLE.
- Watchdog:
  - Counter increments each cycle with tvalid=1 and tready=0, saturating at STALL_LIMIT.
  - Counter clears to 0 on any handshake and in IDLE.
  - stall = (counter == STALL_LIMIT), registered.
  - stall deasserts on the edge after a handshake.
- Widths: tuser/ch are log2(N_CHAN) bits, so the wrap is natural overflow. Watchdog counter is clog2(STALL_LIMIT+1) bits.

Test Plan:
- Reset, write shadow[i]=0x1000*(i+1) for all i, commit, enable=1, tready=1 -> commit_pending clears; tdata sequence 0x1000..0x8000, tuser 0..7, tlast on beat 8; repeats with no bubbles.
- Mid-frame commit: streaming with active=0x1000*(i+1); at beat 3 write shadow[*]=0xA0000000 and commit -> beats 3..7 keep old values; the first beat after tlast is 0xA0000000; commit_pending is high until that tlast-accept edge.
- Backpressure: drop tready for 5 cycles at beat 2 -> tvalid stays 1 and tdata/tuser hold channel 2 values; stream resumes at channel 2 with no skip or duplicate.
- Stall watchdog, STALL_LIMIT=16, tready=0 for 20 cycles -> stall rises after 16 backpressured cycles and holds; one handshake clears it the next cycle.
- enable drop at beat 4 -> beats 4..7 still delivered with tlast, then tvalid=0; re-enable restarts at ch=0.
- Async reset asserted mid-frame while commit is pending -> outputs zero immediately without a clock edge; commit_pending=0; after release and enable, tdata=0 for all channels.
